// File: rtl/t_sram_buffer_pkg.sv
// Shared constants, state encoding and header/count helpers for the
// T-sequence SRAM buffer.
package t_sram_buffer_pkg;

    localparam int GROUP_BITS = 18;
    localparam int T_PER_WORD = 7;
    localparam int PAYLOAD_W  = T_PER_WORD * GROUP_BITS;
    localparam int SRAM_WORD  = 4 + PAYLOAD_W;
    localparam int MAX_T_LOG  = 12;
    localparam int ADDR_W     = 10;
    localparam int BASE_W     = MAX_T_LOG + 1;

    // Response header layout: valid bit on top, 3-bit group count below it.
    localparam int HDR_VALID_BIT = SRAM_WORD - 1;
    localparam int HDR_CNT_W     = 3;
    localparam int HDR_CNT_LSB   = SRAM_WORD - 1 - HDR_CNT_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // A word is the last of the sequence when it reaches or passes group T_size-1.
    function automatic logic is_last_word(input logic [BASE_W-1:0]    base,
                                          input logic [MAX_T_LOG-1:0] t_size);
        return (base + BASE_W'(T_PER_WORD)) >= {1'b0, t_size};
    endfunction

    // Groups present in the word starting at base; a full word encodes as 0.
    // The remainder is below 7 whenever it is used, so 3-bit arithmetic suffices.
    function automatic logic [HDR_CNT_W-1:0] enc_count(input logic [BASE_W-1:0]    base,
                                                       input logic [MAX_T_LOG-1:0] t_size);
        logic [HDR_CNT_W-1:0] w_rem;
        w_rem = t_size[HDR_CNT_W-1:0] - base[HDR_CNT_W-1:0];
        if ((base + BASE_W'(T_PER_WORD)) > {1'b0, t_size}) begin
            return w_rem;
        end
        return '0;
    endfunction

endpackage

// File: rtl/t_sram_buffer_sram_2p.sv
// One-read/one-write synchronous memory with a registered read port.
// Read-first on same-address collision; contents are never reset.
module t_sram_buffer_sram_2p
    import t_sram_buffer_pkg::*;
#(
    parameter int AW = ADDR_W,
    parameter int DW = PAYLOAD_W
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];
    logic [DW-1:0] r_rdata;

    // Write and registered read in one block; non-blocking order yields old data on collision.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/t_sram_buffer.sv
// Word-organised T / boundary storage between host loading and the data
// processor. Holds the control FSM, load/read/write pointers with their
// group bases, request acceptance and response header assembly.
module t_sram_buffer
    import t_sram_buffer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [MAX_T_LOG-1:0] i_T_size,
    input  logic                 i_load_start,
    input  logic                 i_load_valid,
    input  logic [PAYLOAD_W-1:0] i_load_data,
    output logic                 o_load_done,
    input  logic                 i_start_calc,
    input  logic                 i_init,
    input  logic                 i_sram_request,
    output logic [SRAM_WORD-1:0] o_request_data,
    input  logic                 i_sram_send,
    input  logic [SRAM_WORD-1:0] i_send_data
);

    state_t r_state;
    state_t w_next_state;

    logic [MAX_T_LOG-1:0] r_t_size;
    logic [ADDR_W-1:0]    r_ld_addr;
    logic [ADDR_W-1:0]    r_rd_addr;
    logic [ADDR_W-1:0]    r_wr_addr;
    logic [BASE_W-1:0]    r_ld_base;
    logic [BASE_W-1:0]    r_rd_base;
    logic [BASE_W-1:0]    r_wr_base;
    logic                 r_load_done;
    logic                 r_resp_vld;
    logic [HDR_CNT_W-1:0] r_resp_cnt;

    logic w_enter_load;
    logic w_enter_run;
    logic w_ld_fire;
    logic w_rd_fire;
    logic w_wr_fire;
    logic w_ld_last;
    logic w_rd_last;
    logic w_wr_last;

    logic                 w_mem_we;
    logic [ADDR_W-1:0]    w_mem_waddr;
    logic [PAYLOAD_W-1:0] w_mem_wdata;
    logic [PAYLOAD_W-1:0] w_mem_rdata;
    logic [3:0]           w_unused_send_hdr;

    assign w_ld_last = is_last_word(r_ld_base, r_t_size);
    assign w_rd_last = is_last_word(r_rd_base, r_t_size);
    assign w_wr_last = is_last_word(r_wr_base, r_t_size);

    // The header bits of a write word carry nothing worth storing.
    assign w_unused_send_hdr = i_send_data[SRAM_WORD-1:PAYLOAD_W];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state plus per-cycle load/read/write strobes; i_init pre-empts RUN traffic.
    always_comb begin
        w_next_state = r_state;
        w_enter_load = 1'b0;
        w_enter_run  = 1'b0;
        w_ld_fire    = 1'b0;
        w_rd_fire    = 1'b0;
        w_wr_fire    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_load_start) begin
                    w_next_state = ST_LOAD;
                    w_enter_load = 1'b1;
                end else if (i_start_calc) begin
                    w_next_state = ST_RUN;
                    w_enter_run  = 1'b1;
                end
            end
            ST_LOAD: begin
                if (i_load_valid) begin
                    w_ld_fire = 1'b1;
                    if (w_ld_last) begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
            ST_RUN: begin
                if (i_init) begin
                    w_next_state = ST_IDLE;
                end else begin
                    // A request landing on a response cycle is dropped, not queued.
                    w_rd_fire = i_sram_request && !r_resp_vld;
                    w_wr_fire = i_sram_send;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Capture the sequence length whenever a LOAD or RUN session opens.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_t_size <= '0;
        end else if (w_enter_load || w_enter_run) begin
            r_t_size <= i_T_size;
        end
    end

    // Load pointer: cleared on LOAD entry, advances seven groups per host word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ld_addr <= '0;
            r_ld_base <= '0;
        end else if (w_enter_load || (w_ld_fire && w_ld_last)) begin
            r_ld_addr <= '0;
            r_ld_base <= '0;
        end else if (w_ld_fire) begin
            r_ld_addr <= r_ld_addr + ADDR_W'(1);
            r_ld_base <= r_ld_base + BASE_W'(T_PER_WORD);
        end
    end

    // Read pointer: cleared on RUN entry, wraps after the last word of the sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_addr <= '0;
            r_rd_base <= '0;
        end else if (w_enter_run || (w_rd_fire && w_rd_last)) begin
            r_rd_addr <= '0;
            r_rd_base <= '0;
        end else if (w_rd_fire) begin
            r_rd_addr <= r_rd_addr + ADDR_W'(1);
            r_rd_base <= r_rd_base + BASE_W'(T_PER_WORD);
        end
    end

    // Write-back pointer: same clear and wrap rule as the read side, fully independent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_addr <= '0;
            r_wr_base <= '0;
        end else if (w_enter_run || (w_wr_fire && w_wr_last)) begin
            r_wr_addr <= '0;
            r_wr_base <= '0;
        end else if (w_wr_fire) begin
            r_wr_addr <= r_wr_addr + ADDR_W'(1);
            r_wr_base <= r_wr_base + BASE_W'(T_PER_WORD);
        end
    end

    // Response valid and group count, aligned with the memory's registered read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_vld <= 1'b0;
            r_resp_cnt <= '0;
        end else begin
            r_resp_vld <= w_rd_fire;
            if (w_rd_fire) begin
                r_resp_cnt <= enc_count(r_rd_base, r_t_size);
            end
        end
    end

    // Load-complete flag: set by the final load word, held until IDLE is left.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_load_done <= 1'b0;
        end else if (w_enter_load || w_enter_run) begin
            r_load_done <= 1'b0;
        end else if (w_ld_fire && w_ld_last) begin
            r_load_done <= 1'b1;
        end
    end

    // LOAD and RUN never overlap, so they share the single write port.
    always_comb begin
        w_mem_we    = w_ld_fire || w_wr_fire;
        w_mem_waddr = r_wr_addr;
        w_mem_wdata = i_send_data[PAYLOAD_W-1:0];
        if (w_ld_fire) begin
            w_mem_waddr = r_ld_addr;
            w_mem_wdata = i_load_data;
        end
    end

    t_sram_buffer_sram_2p #(
        .AW (ADDR_W),
        .DW (PAYLOAD_W)
    ) u_sram (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (w_mem_waddr),
        .i_wdata (w_mem_wdata),
        .i_re    (w_rd_fire),
        .i_raddr (r_rd_addr),
        .o_rdata (w_mem_rdata)
    );

    // Response word is all zero outside the valid pulse, hiding the unreset read register.
    always_comb begin
        o_request_data = '0;
        if (r_resp_vld) begin
            o_request_data[HDR_VALID_BIT]                  = 1'b1;
            o_request_data[HDR_CNT_LSB +: HDR_CNT_W]       = r_resp_cnt;
            o_request_data[PAYLOAD_W-1:0]                  = w_mem_rdata;
        end
    end

    assign o_load_done = r_load_done;

endmodule
